// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver slice.
//   rx_state_t     : receiver FSM state encoding (one encoding left unused)
//   PAR_*          : parity-mode values for the PARITY parameter
//   SMP_*          : strobe-counter values at which the line is sampled
//   maj3()         : 2-of-3 majority vote
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_PARITY  = 3'd3,
      ST_STOP    = 3'd4,
      ST_DONE    = 3'd5,
      ST_BRKWAIT = 3'd6
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Decision points: mid start bit, and mid bit for every later bit.
   localparam logic [3:0] SMP_START    = 4'd7;
   localparam logic [3:0] SMP_BIT      = 4'd15;
   // Extra sample points feeding the majority vote.
   localparam logic [3:0] SMP_START_M1 = 4'd5;
   localparam logic [3:0] SMP_START_M2 = 4'd6;
   localparam logic [3:0] SMP_BIT_M1   = 4'd13;
   localparam logic [3:0] SMP_BIT_M2   = 4'd14;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler -- turns the synchronized line into the bit value used at a
// decision point.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bit_i        : synchronized serial input
//   stb_i        : 16x baud strobe
//   cnt_i        : receiver strobe counter
//   smp_o        : sampled bit, valid on the strobe at the decision point
// Build option UART_RX_MAJORITY_EN: vote 2-of-3 over the two preceding sample
// points and the decision point; otherwise the decision-point sample is used.
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       bit_i,
   input  logic       stb_i,
   input  logic [3:0] cnt_i,
   output logic       smp_o
);

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;

   // History of the two samples preceding the decision point. The start-bit
   // points (5,6) are simply overwritten by 13,14 in every later bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hist_q <= 2'b11;
      end else if (stb_i && (cnt_i == SMP_START_M1 || cnt_i == SMP_START_M2 ||
                             cnt_i == SMP_BIT_M1   || cnt_i == SMP_BIT_M2)) begin
         hist_q <= {hist_q[0], bit_i};
      end
   end

   assign smp_o = maj3(hist_q[1], hist_q[0], bit_i);
`else
   // Single-sample build needs no history; timing is set by the caller.
   logic unused_sampler_inputs;
   assign unused_sampler_inputs = ^{clk_i, rst_i, stb_i, cnt_i};
   assign smp_o = bit_i;
`endif

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext -- UART receiver, 16x oversampling, configurable frame format.
//   DATA_BITS (5..9), PARITY (PAR_NONE/PAR_EVEN/PAR_ODD), STOP_BITS (1..2)
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset
//   brg_stb_i  : 16x baud strobe, one clk_i wide
//   din_i      : asynchronous serial input, idle high
//   dout_o     : last received word (first bit on the line is the LSB)
//   done_stb_o : one-cycle pulse when a frame completes
//   perr_o     : parity error of the last frame
//   ferr_o     : framing error of the last frame
//   brk_o      : break (all-zero frame) in the last frame
// Build option UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
module uart_rx_ext
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 brg_stb_i,
   input  logic                 din_i,
   output logic [DATA_BITS-1:0] dout_o,
   output logic                 done_stb_o,
   output logic                 perr_o,
   output logic                 ferr_o,
   output logic                 brk_o
);

   logic                 sync1_q, sync2_q;
   rx_state_t            state_q, state_n;
   logic [3:0]           cnt_q;
   logic [3:0]           bit_cnt_q;
   logic                 stop_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_acc_q, perr_q, ferr_q, brk_q;
   logic                 smp, smp_pt, last_data, last_stop;

   // Input synchronizer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= din_i;
         sync2_q <= sync1_q;
      end
   end

   uart_rx_sampler u_sampler (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bit_i (sync2_q),
      .stb_i (brg_stb_i),
      .cnt_i (cnt_q),
      .smp_o (smp)
   );

   // Decision strobe: mid start bit in START, mid bit everywhere else.
   assign smp_pt    = brg_stb_i && (cnt_q == ((state_q == ST_START) ? SMP_START : SMP_BIT));
   assign last_data = (bit_cnt_q == 4'(DATA_BITS - 1));
   assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));

   // Next-state logic
   always_comb begin
      state_n = state_q;
      case (state_q)
         ST_IDLE:    if (!sync2_q) state_n = ST_START;
         ST_START:   if (smp_pt) state_n = smp ? ST_IDLE : ST_DATA;
         ST_DATA:    if (smp_pt && last_data)
                        state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY:  if (smp_pt) state_n = ST_STOP;
         ST_STOP:    if (smp_pt && last_stop) state_n = ST_DONE;
         ST_DONE:    state_n = ferr_q ? ST_BRKWAIT : ST_IDLE;
         ST_BRKWAIT: if (sync2_q) state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
   end

   // State register and strobe counter (cleared on every state change, so it
   // wraps 15->0 between consecutive data or stop bits).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_n;
         if (state_n != state_q) cnt_q <= 4'd0;
         else if (brg_stb_i)     cnt_q <= cnt_q + 4'd1;
      end
   end

   // Per-frame accumulators; primed while idle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bit_cnt_q  <= 4'd0;
         stop_cnt_q <= 1'b0;
         par_acc_q  <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               bit_cnt_q  <= 4'd0;
               stop_cnt_q <= 1'b0;
               par_acc_q  <= 1'b0;
               perr_q     <= 1'b0;
               ferr_q     <= 1'b0;
               brk_q      <= 1'b1;
            end
            ST_DATA: if (smp_pt) begin
               bit_cnt_q <= bit_cnt_q + 4'd1;
               par_acc_q <= par_acc_q ^ smp;
               brk_q     <= brk_q & ~smp;
            end
            ST_PARITY: if (smp_pt) begin
               perr_q <= (smp != ((PARITY == PAR_ODD) ? ~par_acc_q : par_acc_q));
               brk_q  <= brk_q & ~smp;
            end
            ST_STOP: if (smp_pt) begin
               stop_cnt_q <= stop_cnt_q + 1'b1;
               ferr_q     <= ferr_q | ~smp;
               // Only the first stop bit counts toward a break.
               if (!stop_cnt_q) brk_q <= brk_q & ~smp;
            end
            default: ;
         endcase
      end
   end

   // Data shift register, LSB first
   always_ff @(posedge clk_i) begin
      if (state_q == ST_DATA && smp_pt) shift_q <= {smp, shift_q[DATA_BITS-1:1]};
   end

   // Output registers: updated together, one cycle after DONE
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dout_o     <= '1;
         done_stb_o <= 1'b0;
         perr_o     <= 1'b0;
         ferr_o     <= 1'b0;
         brk_o      <= 1'b0;
      end else begin
         done_stb_o <= (state_q == ST_DONE);
         if (state_q == ST_DONE) begin
            dout_o <= shift_q;
            perr_o <= perr_q;
            ferr_o <= ferr_q;
            brk_o  <= brk_q;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext -- bench for uart_rx_ext. Three receivers with different
// frame formats run side by side; a frame-level model predicts each completed
// frame and a single compare process checks all outputs every cycle.
module tb_uart_rx_ext;

   localparam int STB_DIV = 3;            // clocks per 16x strobe
   localparam int BT      = 16 * STB_DIV; // clocks per bit
   localparam int NRAND   = 25;

   typedef struct packed {
      logic [8:0] dout;
      logic       perr;
      logic       ferr;
      logic       brk;
   } res_t;

   logic       clk = 1'b0;
   logic       brg_stb = 1'b0;
   logic [2:0] rst = 3'b111;
   logic [2:0] din = 3'b111;
   logic [7:0] dout0;
   logic [6:0] dout1;
   logic [7:0] dout2;
   logic [2:0] done, perr, ferr, brk;

   int   checks = 0;
   int   errors = 0;
   int   ndone[3] = '{0, 0, 0};
   res_t cur[3];
   res_t q0[$], q1[$], q2[$];

   always #5 clk = ~clk;

   initial begin
      int c = 0;
      forever begin
         @(negedge clk);
         brg_stb = (c == 0);
         c = (c + 1) % STB_DIV;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   uart_rx_ext #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
      .clk_i(clk), .rst_i(rst[0]), .brg_stb_i(brg_stb), .din_i(din[0]),
      .dout_o(dout0), .done_stb_o(done[0]), .perr_o(perr[0]), .ferr_o(ferr[0]), .brk_o(brk[0]));

   uart_rx_ext #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst[1]), .brg_stb_i(brg_stb), .din_i(din[1]),
      .dout_o(dout1), .done_stb_o(done[1]), .perr_o(perr[1]), .ferr_o(ferr[1]), .brk_o(brk[1]));

   uart_rx_ext #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut2 (
      .clk_i(clk), .rst_i(rst[2]), .brg_stb_i(brg_stb), .din_i(din[2]),
      .dout_o(dout2), .done_stb_o(done[2]), .perr_o(perr[2]), .ferr_o(ferr[2]), .brk_o(brk[2]));

   function automatic int dbits(input int u);
      return (u == 1) ? 7 : 8;
   endfunction

   function automatic int parmode(input int u);
      return u; // 0 none, 1 even, 2 odd
   endfunction

   function automatic int sbits(input int u);
      return (u == 2) ? 2 : 1;
   endfunction

   function automatic logic [8:0] mask(input int u);
      return 9'((10'h1 << dbits(u)) - 10'h1);
   endfunction

   function automatic logic [8:0] dout_of(input int u);
      case (u)
         0:       return {1'b0, dout0};
         1:       return {2'b0, dout1};
         default: return {1'b0, dout2};
      endcase
   endfunction

   function automatic logic good_par(input int u, input logic [8:0] data);
      logic x;
      x = ^(data & mask(u));
      return (parmode(u) == 2) ? ~x : x;
   endfunction

   // What a frame must produce, from the bits put on the line.
   function automatic res_t model(input int u, input logic [8:0] data, input logic pbit,
                                  input logic [1:0] stv);
      res_t       r;
      logic [8:0] d;
      d      = data & mask(u);
      r.dout = d;
      r.perr = (parmode(u) == 0) ? 1'b0 : (pbit != good_par(u, d));
      r.ferr = !stv[0] || (sbits(u) == 2 && !stv[1]);
      r.brk  = (d == 9'h0) && (parmode(u) == 0 || !pbit) && !stv[0];
      return r;
   endfunction

   function automatic int qsize(input int u);
      case (u)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic push(input int u, input res_t r);
      case (u)
         0:       q0.push_back(r);
         1:       q1.push_back(r);
         default: q2.push_back(r);
      endcase
   endtask

   function automatic res_t qpop(input int u);
      case (u)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic line_bit(input int u, input logic v, input int nbits);
      din[u] = v;
      repeat (nbits * BT) @(negedge clk);
   endtask

   task automatic send_frame(input int u, input logic [8:0] data, input logic pbit,
                             input logic [1:0] stv, input int hold);
      logic last;
      push(u, model(u, data, pbit, stv));
      line_bit(u, 1'b0, 1);
      for (int i = 0; i < dbits(u); i++) line_bit(u, data[i], 1);
      if (parmode(u) != 0) line_bit(u, pbit, 1);
      line_bit(u, stv[0], 1);
      if (sbits(u) == 2) line_bit(u, stv[1], 1);
      last = (sbits(u) == 2) ? stv[1] : stv[0];
      if (hold > 0 && !last) line_bit(u, 1'b0, hold);
      line_bit(u, 1'b1, 2);
   endtask

   task automatic rand_run(input int u);
      logic [8:0] data;
      logic       pbit;
      logic [1:0] stv;
      int         hold;
      for (int n = 0; n < NRAND; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            din[u] = 1'b0;
            repeat ($urandom_range(1, 5) * STB_DIV) @(negedge clk);
            line_bit(u, 1'b1, 1);
         end
         repeat ($urandom_range(0, BT)) @(negedge clk);
         data = 9'($urandom);
         hold = 0;
         if ($urandom_range(0, 7) == 0) begin
            data = 9'h0;
            pbit = 1'b0;
            stv  = 2'b00;
            hold = $urandom_range(0, 3);
         end else begin
            pbit   = good_par(u, data) ^ ($urandom_range(0, 3) == 0);
            stv[0] = ($urandom_range(0, 5) != 0);
            stv[1] = ($urandom_range(0, 5) != 0);
         end
         send_frame(u, data, pbit, stv, hold);
      end
   endtask

   // Compare process: every cycle, each receiver either is in reset, reports
   // a predicted frame, or holds its previous outputs.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         for (int u = 0; u < 3; u++) begin
            logic [8:0] ad;
            res_t       e;
            ad = dout_of(u);
            if (rst[u]) begin
               cur[u] = {mask(u), 3'b000};
               chk($sformatf("u%0d_reset_state", u),
                   {done[u], ad, perr[u], ferr[u], brk[u]}, {1'b0, mask(u), 3'b000});
            end else if (done[u]) begin
               ndone[u]++;
               chk($sformatf("u%0d_done_expected", u), (qsize(u) != 0), 1);
               if (qsize(u) != 0) begin
                  e = qpop(u);
                  chk($sformatf("u%0d_frame", u), {ad, perr[u], ferr[u], brk[u]}, e);
                  cur[u] = e;
               end
            end else begin
               chk($sformatf("u%0d_hold", u), {ad, perr[u], ferr[u], brk[u]}, cur[u]);
               cur[u] = {ad, perr[u], ferr[u], brk[u]};
            end
         end
      end
   end

   initial begin
      int base;
      rst = 3'b111;
      din = 3'b111;
      repeat (5) @(negedge clk);
      #1;
      chk("reset_dout0", dout0, 8'hFF);
      chk("reset_dout1", dout1, 7'h7F);
      chk("reset_flags", {done, perr, ferr, brk}, 12'h000);
      @(negedge clk);
      rst = 3'b000;
      repeat (2 * BT) @(negedge clk);

      // 8-N-1 frame 0x55
      base = ndone[0];
      send_frame(0, 9'h55, 1'b0, 2'b11, 0);
      #1;
      chk("f55_dout", dout0, 8'h55);
      chk("f55_flags", {perr[0], ferr[0], brk[0]}, 3'b000);
      chk("f55_ndone", ndone[0] - base, 1);

      // 7-E-1: 0x41 with parity bit 1 (wrong) then 0 (right)
      send_frame(1, 9'h41, 1'b1, 2'b11, 0);
      #1;
      chk("f41p1_dout", dout1, 7'h41);
      chk("f41p1_perr", perr[1], 1'b1);
      send_frame(1, 9'h41, 1'b0, 2'b11, 0);
      #1;
      chk("f41p0_dout", dout1, 7'h41);
      chk("f41p0_perr", perr[1], 1'b0);

      // Glitch of 4 strobe periods: no frame, outputs unchanged
      base = ndone[0];
      din[0] = 1'b0;
      repeat (4 * STB_DIV) @(negedge clk);
      line_bit(0, 1'b1, 2);
      #1;
      chk("glitch_ndone", ndone[0] - base, 0);
      chk("glitch_dout", dout0, 8'h55);

      // 8-O-2 frame 0xA3, second stop bit low, line stays low a while
      base = ndone[2];
      send_frame(2, 9'hA3, 1'b1, 2'b01, 3);
      #1;
      chk("fA3_dout", dout2, 8'hA3);
      chk("fA3_flags", {perr[2], ferr[2], brk[2]}, 3'b010);
      chk("fA3_ndone", ndone[2] - base, 1);

      // Break: line low for 30 bit times, then a normal frame
      base = ndone[0];
      send_frame(0, 9'h00, 1'b0, 2'b00, 20);
      #1;
      chk("brk_ndone", ndone[0] - base, 1);
      chk("brk_dout", dout0, 8'h00);
      chk("brk_flags", {perr[0], ferr[0], brk[0]}, 3'b011);
      send_frame(0, 9'h12, 1'b0, 2'b11, 0);
      #1;
      chk("f12_dout", dout0, 8'h12);
      chk("f12_flags", {perr[0], ferr[0], brk[0]}, 3'b000);

      // Reset in the middle of frame 0xFF, then frame 0x3C
      base = ndone[0];
      line_bit(0, 1'b0, 1);
      line_bit(0, 1'b1, 1);
      repeat (BT / 2) @(negedge clk);
      rst[0] = 1'b1;
      repeat (3) @(negedge clk);
      rst[0] = 1'b0;
      repeat (9 * BT) @(negedge clk);
      #1;
      chk("rstmid_dout", dout0, 8'hFF);
      chk("rstmid_flags", {done[0], perr[0], ferr[0], brk[0]}, 4'h0);
      chk("rstmid_ndone", ndone[0] - base, 0);
      send_frame(0, 9'h3C, 1'b0, 2'b11, 0);
      #1;
      chk("f3C_dout", dout0, 8'h3C);

      // Randomized traffic on all three receivers at once
      fork
         rand_run(0);
         rand_run(1);
         rand_run(2);
      join
      repeat (2 * BT) @(negedge clk);
      #1;
      for (int u = 0; u < 3; u++) chk($sformatf("u%0d_frames_left", u), qsize(u), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-004 SHALL have port clk_i  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port brg_stb_i  in  1  16x-oversample baud strobe, one clk_i wide.
REQ-007 SHALL have port din_i  in  1  asynchronous serial input; idle high.
REQ-008 SHALL have port dout_o  out  DATA_BITS  last received word, LSB first on the line.
REQ-009 SHALL have port done_stb_o  out  1  one-cycle pulse marking a completed frame.
REQ-010 SHALL have port perr_o  out  1  parity error of the last frame.
REQ-011 SHALL have port ferr_o  out  1  framing error of the last frame (any stop bit low).
REQ-012 SHALL have port brk_o  out  1  break detected in the last frame.

Function
REQ-013 SHALL pass din_i through a 2-flop synchronizer, reset to 1; all sampling uses its output.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE, BRKWAIT.
REQ-015 SHALL use a 4-bit strobe counter that advances only on brg_stb_i and clears on each state entry.
REQ-016 IDLE: synchronized input low -> START, counter 0.
REQ-017 START: on the 8th strobe, input still low -> DATA, bit counter 0; input high -> IDLE (false start, no done_stb_o, no flag change).
REQ-018 DATA: sample on the strobe where the counter is 15; shift in LSB first; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-019 PARITY: sample at counter 15; perr = sample != expected (even: XOR of data bits; odd: its inverse) -> STOP.
REQ-020 STOP: sample STOP_BITS bits at counter 15 each; ferr set if any sampled stop bit is 0 -> DONE.
REQ-021 DONE: one cycle; next cycle dout_o, perr_o, ferr_o, brk_o update together and done_stb_o is high for exactly one clk_i.
REQ-022 brk SHALL be 1 iff all data bits, the parity bit (if present) and the first stop bit sampled 0; brk implies ferr.
REQ-023 After DONE with ferr=1 -> BRKWAIT, held until synchronized input is high, then IDLE; otherwise DONE -> IDLE.
REQ-024 dout_o and flags SHALL hold between done pulses; a parity/framing error frame still updates dout_o.
REQ-025 An unused state encoding SHALL return to IDLE on the next clock.
REQ-026 brg_stb_i absent SHALL freeze all counters and the state; no timeout.

Reset
REQ-027 rst_i high SHALL immediately force IDLE, counters 0, dout_o all ones, done_stb_o/perr_o/ferr_o/brk_o 0, synchronizer 1.
REQ-028 Reset mid-frame SHALL discard the partial frame; after release, reception starts only on a new falling edge.

Configuration
REQ-029 With UART_RX_MAJORITY_EN defined, each bit value SHALL be the 2-of-3 majority of samples at counters 13, 14, 15 (START check uses counters 5, 6, 7).
REQ-030 Without UART_RX_MAJORITY_EN, each bit value SHALL be the single sample at counter 15 (START at counter 7); timing is identical in both builds.

Structure
REQ-031 State encodings, parity-mode constants (PAR_NONE/PAR_EVEN/PAR_ODD) and sample-point constants SHALL live in shared package uart_pkg.
REQ-032 The majority/sample logic SHALL be sub-module uart_rx_sampler (input synchronized bit, strobe, counter; output sampled bit).

Verification
REQ-033 8-N-1, frame 0x55 at 16x strobes -> done_stb_o one cycle, dout_o=0x55, perr/ferr/brk=0.
REQ-034 DATA_BITS=7, PARITY=1, byte 0x41 with parity bit 1 -> dout_o=0x41, perr_o=1; same with parity 0 -> perr_o=0.
REQ-035 Low pulse of 4 strobe periods on idle line -> no done_stb_o, outputs unchanged, back to IDLE.
REQ-036 STOP_BITS=2, second stop bit 0, data 0xA3 -> dout_o=0xA3, ferr_o=1, brk_o=0; no new frame until line high.
REQ-037 Line held low 30 bit times -> one done_stb_o, dout_o=0x00, ferr_o=1, brk_o=1; next frame 0x12 after line high received correctly.
REQ-038 rst_i pulsed mid-DATA of frame 0xFF -> outputs at reset values, no done_stb_o; following frame 0x3C received as 0x3C.
